serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller. It time-shares one instance of the team's single-bit `full_adder` across a WIDTH-bit operand pair, feeding one bit pair per clock and carrying the result forward in a register. A start/busy/done handshake brackets each operation. It serves as the area-minimal adder for the design: multi-bit addition using one full-adder cell.

## Interface
- `WIDTH`, default 8. Operand and sum width; legal range 2..32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a new addition; sampled only in IDLE.
- `a` in WIDTH: operand A, captured on the accepted `start`.
- `b` in WIDTH: operand B, captured on the accepted `start`.
- `cin` in 1: carry-in, captured on the accepted `start`.
- `busy` out 1: high while bit-serial addition is in progress.
- `done` out 1: one-cycle pulse when `sum` and `cout` update.
- `sum` out WIDTH: registered result; holds the last completed value.
- `cout` out 1: registered final carry; holds the last completed value.

## Operation
- FSM states: IDLE, ADD, DONE.
- **IDLE**
  - `start`=1 loads `a` into shift register SA and `b` into SB.
  - It loads `cin` into the carry register CY and clears bit counter CNT; next state is ADD.
  - `start`=0: remain in IDLE.
- **ADD**, each cycle:
  - Full-adder inputs are SA[0], SB[0], CY.
  - SA and SB shift right by one.
  - The full-adder `s` shifts into the MSB of working register SW (shift right).
  - CY takes the full-adder `cout`; CNT increments.
  - When CNT = WIDTH-1 in this cycle: `sum` takes the final SW value including this bit, and `cout` takes the full-adder `cout`. Next state is DONE.
- **DONE**: `done`=1 for this cycle only; next state is IDLE unconditionally.
- `start` is ignored in ADD and DONE. There is no queuing; the requester must wait for `done`.
- `a`, `b` and `cin` may change freely after the accepted `start`.
- `sum` and `cout` change only on the edge entering DONE; they are stable at all other times, including during ADD.
- Arithmetic is modulo 2^WIDTH with the carry in `cout`. {`cout`,`sum`} = `a` + `b` + `cin` exactly.
- CNT width is $clog2(WIDTH). It never wraps within one operation because the FSM leaves ADD at WIDTH-1.
- Reset (`rst_n`=0 at an edge), from any state including mid-ADD:
  - state goes to IDLE; the partial result is discarded.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - SA, SB, SW, CY and CNT are cleared.
- Reset has priority over `start` on the same edge.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0.
- `start` accepted at edge k:
  - `busy`=1 in cycles k+1 .. k+WIDTH.
  - `done`=1 in cycle k+WIDTH+1, with the new `sum`/`cout` visible that same cycle.
- Latency is WIDTH+1 cycles from accepted `start` to `done`.
- Minimum start-to-start interval is WIDTH+2 cycles. `start` held high continuously is accepted every WIDTH+2 cycles.
- `busy` and `done` are never high together.
- All outputs are registered.
- The full-adder path is combinational inside one cycle: shift-register LSBs → `full_adder` → SW/CY.

## Structure
- Shared package `serial_adder_pkg` holds:
  - the state enum (IDLE=2'd0, ADD=2'd1, DONE=2'd2);
  - the default-width constant `SA_WIDTH_DEFAULT`=8.
- The one sub-module is the existing `full_adder` (ports a, b, cin, s, cout), instantiated once, unmodified.
- Everything else is in `serial_adder_ctrl`: FSM, counter, shift registers, result registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start for one cycle → `busy` for 8 cycles, `done` pulse 9 cycles after start, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1; the previous sum 0x00 holds throughout the second ADD.
- Pulse `start` again at cycles 3 and 8 of an ADD with different operands → ignored; result matches the first operands only; exactly one `done`.
- Assert `rst_n`=0 for one cycle at ADD cycle 4 → next cycle all outputs 0 and IDLE. A subsequent start with a=0x01, b=0x02, cin=0 gives sum=0x03, cout=0.
- Hold `start`=1 continuously for three operations → `done` pulses spaced exactly 10 cycles apart; each result is correct for the operands present at its accept edge.
- WIDTH=3 exhaustive: all 128 {a,b,cin} combinations → {cout,sum} equals a+b+cin every time; latency is always 4 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
package serial_adder_pkg;

    localparam int SA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sharing one full_adder across WIDTH bits
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_e        state;
    sa_state_e        state_next;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sw_q;
    logic             cy_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (cy_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are flopped from the next state so they align with the state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_q  <= '0;
            sb_q  <= '0;
            sw_q  <= '0;
            cy_q  <= 1'b0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            busy <= (state_next == ADD);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sa_q  <= a;
                        sb_q  <= b;
                        cy_q  <= cin;
                        cnt_q <= '0;
                    end
                end
                ADD: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    sw_q  <= {fa_s, sw_q[WIDTH-1:1]};
                    cy_q  <= fa_cout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum  <= {fa_s, sw_q[WIDTH-1:1]};
                        cout <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

    localparam int W8 = 8;
    localparam int W3 = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0;
    logic [2:0] b3 = '0;
    logic       cin3 = 1'b0;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    serial_adder_ctrl #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(W3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .a     (a3),
        .b     (b3),
        .cin   (cin3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Timing model and scoreboard for the 8-bit instance: accept-edge bookkeeping only
    int         ecount = 0;
    int         acc8 = -1000;
    logic       exp_busy8 = 1'b0;
    logic       exp_done8 = 1'b0;
    logic [8:0] exp_res8 = '0;
    logic [8:0] sb8[$];

    always @(posedge clk) begin : model8
        int acc_n;
        int d;
        acc_n = acc8;
        if (!rst_n) begin
            acc8      <= -1000;
            exp_busy8 <= 1'b0;
            exp_done8 <= 1'b0;
            exp_res8  <= '0;
            sb8.delete();
        end else begin
            if (start8 && (ecount - acc8 >= W8 + 2)) begin
                acc_n = ecount;
                sb8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
            end
            d = ecount - acc_n;
            exp_busy8 <= (d >= 0) && (d < W8);
            exp_done8 <= (d == W8);
            if (d == W8 && sb8.size() > 0) exp_res8 <= sb8.pop_front();
            acc8 <= acc_n;
        end
        ecount <= ecount + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy8", busy8, exp_busy8);
            chk("done8", done8, exp_done8);
            chk("result8", {cout8, sum8}, exp_res8);
            chk("busy8_done8_exclusive", busy8 & done8, 0);
            chk("busy3_done3_exclusive", busy3 & done3, 0);
        end
    end

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 1;
        while (!done8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;
        int dpos[$];
        logic [3:0] exp3;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy8", busy8, 0);
        chk("reset_done8", done8, 0);
        chk("reset_sum8", sum8, 0);
        chk("reset_cout8", cout8, 0);
        chk("reset_busy3", busy3, 0);
        chk("reset_sum3", {cout3, sum3}, 0);
        chk_en = 1'b1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op8(tbl[i].a, tbl[i].b, tbl[i].cin, lat);
            chk("table_latency", lat, W8 + 1);
            chk("table_sum", sum8, tbl[i].sum);
            chk("table_cout", cout8, tbl[i].cout);
        end

        // extra starts during ADD must be ignored
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start8 = (n == 3 || n == 8);
            a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
            if (done8) begin
                ndone++;
                chk("ignored_start_done_cycle", n, W8 + 1);
                chk("ignored_start_result", {cout8, sum8}, 9'h033);
            end
        end
        start8 = 1'b0;
        chk("ignored_start_done_count", ndone, 1);

        // reset in ADD cycle 4
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midadd_reset_busy", busy8, 0);
        chk("midadd_reset_done", done8, 0);
        chk("midadd_reset_sum", sum8, 0);
        chk("midadd_reset_cout", cout8, 0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("midadd_reset_no_done", ndone, 0);
        run_op8(8'h01, 8'h02, 1'b0, lat);
        chk("post_reset_latency", lat, W8 + 1);
        chk("post_reset_result", {cout8, sum8}, 9'h003);

        // start held high: accepted every WIDTH+2 cycles
        @(negedge clk);
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (n == 28) start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            if (done8) dpos.push_back(n);
        end
        chk("held_start_done_count", dpos.size(), 3);
        if (dpos.size() == 3) begin
            chk("held_start_first_done", dpos[0], W8 + 1);
            chk("held_start_gap1", dpos[1] - dpos[0], W8 + 2);
            chk("held_start_gap2", dpos[2] - dpos[1], W8 + 2);
        end

        // WIDTH=3 exhaustive
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            @(negedge clk);
            start3 = 1'b1; a3 = v[2:0]; b3 = v[5:3]; cin3 = v[6];
            exp3 = 4'(v[2:0]) + 4'(v[5:3]) + 4'(v[6]);
            @(negedge clk);
            start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
            lat = 1;
            while (!done3 && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            chk("w3_latency", lat, W3 + 1);
            chk("w3_result", {cout3, sum3}, exp3);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
